// File: rtl/dpr_port_master.sv
// Burst initiator for one port of a registered-read dual-port RAM: turns a
// (direction, base, length) command into a stream of RAM writes or credit-limited reads.
module dpr_port_master #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_SIZE-1:0] cmd_addr,
    input  logic [ADDR_SIZE-1:0] cmd_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_SIZE-1:0] ram_din,
    input  logic [DATA_SIZE-1:0] ram_dout,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [ADDR_SIZE-1:0] r_addr;
    logic [ADDR_SIZE-1:0] r_remaining;
    logic [2:0]           r_outstanding;
    logic                 r_ram_en;
    logic                 r_ram_we;
    logic [ADDR_SIZE-1:0] r_ram_addr;
    logic [DATA_SIZE-1:0] r_ram_din;
    logic                 r_wr_done;
    logic                 r_rd_ret;

    logic [DATA_SIZE-1:0] r_fifo [0:3];
    logic [1:0]           r_wptr;
    logic [1:0]           r_rptr;
    logic [2:0]           r_count;

    logic                 w_cmd_ready;
    logic                 w_wr_ready;
    logic                 w_busy;
    logic                 w_issue;
    logic                 w_wr_beat;
    logic                 w_pop;
    logic                 w_last_pop;
    logic                 w_last_beat;

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------- output decode
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_cmd_ready = 1'b0;
        w_wr_ready  = 1'b0;
        w_busy      = 1'b1;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
            end
            S_WRITE: w_wr_ready = 1'b1;
            S_READ:  w_issue    = (r_outstanding < 3'd4);
            default: ;
        endcase
    end

    assign w_wr_beat   = w_wr_ready && wr_valid;
    assign w_last_beat = w_wr_beat && (r_remaining == '0);
    assign w_pop       = (r_count != 3'd0) && rd_ready;
    // Only one read left in flight and it is leaving now: burst complete.
    assign w_last_pop  = (r_state == S_DRAIN) && w_pop && (r_outstanding == 3'd1);

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_next_state = cmd_write ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                if (w_last_beat) w_next_state = S_IDLE;
            end
            S_READ: begin
                if (w_issue && (r_remaining == '0)) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last_pop) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_din     <= '0;
            r_wr_done     <= 1'b0;
            r_rd_ret      <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_ram_en  <= 1'b0;
            r_ram_we  <= 1'b0;
            r_wr_done <= w_last_beat;
            // The RAM returns data one cycle after a read strobe; push it then.
            r_rd_ret  <= r_ram_en && !r_ram_we;

            if (w_cmd_ready && cmd_valid) begin
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len;
            end else if (w_wr_beat || w_issue) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end

            if (w_wr_beat) begin
                r_ram_en   <= 1'b1;
                r_ram_we   <= 1'b1;
                r_ram_addr <= r_addr;
                r_ram_din  <= wr_data;
            end else if (w_issue) begin
                r_ram_en   <= 1'b1;
                r_ram_addr <= r_addr;
            end

            case ({w_issue, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 3'd1;
                2'b01:   r_outstanding <= r_outstanding - 3'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (r_rd_ret) r_wptr <= r_wptr + 2'd1;
            if (w_pop)    r_rptr <= r_rptr + 2'd1;
            case ({r_rd_ret, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; emptiness is tracked by r_count, which is.
    always_ff @(posedge clk) begin
        if (r_rd_ret) r_fifo[r_wptr] <= ram_dout;
    end

    assign cmd_ready = w_cmd_ready;
    assign wr_ready  = w_wr_ready;
    assign busy      = w_busy;
    assign rd_valid  = (r_count != 3'd0);
    assign rd_data   = r_fifo[r_rptr];
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign done      = r_wr_done || w_last_pop;

endmodule

// File: tb/tb_dpr_port_master.sv
// Directed bench for dpr_port_master with a behavioural registered-read RAM
// on its port; RAM accesses, pops and done pulses are logged per cycle.
module tb_dpr_port_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_din, ram_dout;
    logic       busy, done;

    dpr_port_master #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Behavioural RAM port: single-cycle registered read.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
    } acc_t;

    acc_t       acc_q [$];
    int         pop_c [$];
    logic [7:0] pop_d [$];
    int         done_c[$];

    always @(negedge clk) begin
        if (ram_en === 1'b1) acc_q.push_back('{cyc, ram_we, ram_addr, ram_din});
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            pop_c.push_back(cyc);
            pop_d.push_back(rd_data);
        end
        if (done === 1'b1) done_c.push_back(cyc);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_logs();
        acc_q.delete();
        pop_c.delete();
        pop_d.delete();
        done_c.delete();
    endtask

    task automatic drive_cmd(input logic wr, input logic [7:0] a, input logic [7:0] len, output int t_acc);
        @(posedge clk); #1;
        clear_logs();
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = len;
        @(negedge clk); #1;
        t_acc = cyc;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] len, input logic [7:0] d0,
                            input bit toggle, output int t_acc);
        int beats = 0;
        int k     = 0;
        drive_cmd(1'b1, a, len, t_acc);
        while (beats <= int'(len) && k < 600) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            wr_valid  = toggle ? (k % 2 == 0) : 1'b1;
            wr_data   = d0 + 8'(beats);
            @(negedge clk); #1;
            if (wr_valid && wr_ready) beats++;
            k++;
        end
        if (beats <= int'(len)) check("wr_timeout", 32'(beats), 32'(len) + 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // rd_ready is held low for the first `hold` cycles after the accept cycle.
    task automatic do_read(input logic [7:0] a, input logic [7:0] len, input int hold,
                           output int t_acc, output int stall_acc, output logic stall_valid);
        int k   = 0;
        bit fin = 0;
        stall_acc   = -1;
        stall_valid = 1'b0;
        drive_cmd(1'b0, a, len, t_acc);
        rd_ready = (hold == 0);
        while (!fin && k < 600) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            rd_ready  = (k >= hold);
            @(negedge clk); #1;
            if (hold > 0 && k == hold - 1) begin
                stall_acc   = acc_q.size();
                stall_valid = rd_valid;
            end
            if (done) fin = 1;
            k++;
        end
        if (!fin) check("rd_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rd_ready = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [7:0] a, input int n,
                                input logic [7:0] d0, input int first_c, input int stride);
        check({tag, "_count"}, 32'(acc_q.size()), 32'(n));
        for (int i = 0; i < acc_q.size(); i++) begin
            check({tag, "_we"},   {31'd0, acc_q[i].we}, 32'd1);
            check({tag, "_addr"}, 32'(acc_q[i].a), 32'(8'(a + 8'(i))));
            check({tag, "_din"},  32'(acc_q[i].d), 32'(8'(d0 + 8'(i))));
            check({tag, "_cyc"},  32'(acc_q[i].c), 32'(first_c + stride * i));
        end
        check({tag, "_ndone"}, 32'(done_c.size()), 32'd1);
        if (done_c.size() > 0)
            check({tag, "_done_cyc"}, 32'(done_c[0]), 32'(first_c + stride * (n - 1)));
    endtask

    task automatic check_reads(input string tag, input logic [7:0] a, input int n, input logic [7:0] d0);
        check({tag, "_nacc"}, 32'(acc_q.size()), 32'(n));
        for (int i = 0; i < acc_q.size(); i++) begin
            check({tag, "_we"},   {31'd0, acc_q[i].we}, 32'd0);
            check({tag, "_addr"}, 32'(acc_q[i].a), 32'(8'(a + 8'(i))));
        end
        check({tag, "_npop"}, 32'(pop_d.size()), 32'(n));
        for (int i = 0; i < pop_d.size(); i++)
            check({tag, "_data"}, 32'(pop_d[i]), 32'(8'(d0 + 8'(i))));
        check({tag, "_ndone"}, 32'(done_c.size()), 32'd1);
        if (done_c.size() > 0 && pop_c.size() > 0)
            check({tag, "_done_at_last_pop"}, 32'(done_c[0]), 32'(pop_c[pop_c.size()-1]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_en"},    {31'd0, ram_en},    32'd0);
        check({tag, "_ram_we"},    {31'd0, ram_we},    32'd0);
        check({tag, "_ram_addr"},  32'(ram_addr),      32'd0);
        check({tag, "_ram_din"},   32'(ram_din),       32'd0);
        check({tag, "_done"},      {31'd0, done},      32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_rd_valid"},  {31'd0, rd_valid},  32'd0);
        check({tag, "_wr_ready"},  {31'd0, wr_ready},  32'd0);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int   t;
        int   stall_acc;
        logic stall_valid;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Write 0x10..0x13 <- A0..A3, constant wr_valid: accesses at t+2..t+5, done at t+5
        do_write(8'h10, 8'd3, 8'hA0, 1'b0, t);
        check_writes("wr1", 8'h10, 4, 8'hA0, t + 2, 1);

        // Read back with rd_ready=1: ram_en t+2..t+5, pops t+4..t+7, done t+7
        do_read(8'h10, 8'd3, 0, t, stall_acc, stall_valid);
        check_reads("rd1", 8'h10, 4, 8'hA0);
        if (acc_q.size() > 0) check("rd1_first_en_cyc", 32'(acc_q[0].c), 32'(t + 2));
        if (pop_c.size() == 4) begin
            for (int i = 0; i < 4; i++) check("rd1_pop_cyc", 32'(pop_c[i]), 32'(t + 4 + i));
        end
        if (done_c.size() > 0) check("rd1_done_cyc", 32'(done_c[0]), 32'(t + 7));

        // Eight-word read with rd_ready low: four issues then stall with data waiting
        do_write(8'h20, 8'd7, 8'h50, 1'b0, t);
        check_writes("wr8", 8'h20, 8, 8'h50, t + 2, 1);
        do_read(8'h20, 8'd7, 10, t, stall_acc, stall_valid);
        check("rd8_stall_nacc", 32'(stall_acc), 32'd4);
        check("rd8_stall_valid", {31'd0, stall_valid}, 32'd1);
        check_reads("rd8", 8'h20, 8, 8'h50);

        // Address wrap: FE, FF, 00
        do_write(8'hFE, 8'd2, 8'hC0, 1'b0, t);
        check_writes("wrap_wr", 8'hFE, 3, 8'hC0, t + 2, 1);
        do_read(8'hFE, 8'd2, 0, t, stall_acc, stall_valid);
        check_reads("wrap_rd", 8'hFE, 3, 8'hC0);

        // wr_valid every other cycle: accesses at t+2, t+4, t+6, t+8
        do_write(8'h40, 8'd3, 8'h70, 1'b1, t);
        check_writes("tog_wr", 8'h40, 4, 8'h70, t + 2, 2);

        // Single-word bursts
        do_write(8'h80, 8'd0, 8'h99, 1'b0, t);
        check_writes("one_wr", 8'h80, 1, 8'h99, t + 2, 1);
        do_read(8'h80, 8'd0, 0, t, stall_acc, stall_valid);
        check_reads("one_rd", 8'h80, 1, 8'h99);

        // Reset mid-read with three reads outstanding
        drive_cmd(1'b0, 8'h20, 8'd7, t);
        rd_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        @(negedge clk); #1;
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst_n    = 1'b1;
        rd_ready = 1'b1;
        clear_logs();
        @(negedge clk); #1;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_no_pop",  32'(pop_d.size()),  32'd0);
        check("post_rst_no_done", 32'(done_c.size()), 32'd0);
        check("post_rst_no_acc",  32'(acc_q.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
